// File: rtl/iot_sensor_pkg.sv
// Shared types and constants for the sensor packet path.
// Holds the UART serialiser state encoding and frame constants.
package iot_sensor_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_tx_state_e;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/pkt_byte_fifo.sv
// Synchronous byte FIFO with level output; pointers carry an extra MSB so
// full and empty are distinguishable without a separate count register.
module pkt_byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q[AW-1:0]];
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/packet_uart_tx.sv
// Framer-to-UART transmit stage: valid/ack byte capture into a FIFO and an 8N1
// serialiser, LSB first. Define UART_PARITY_EN to add an even-parity bit (8E1).
module packet_uart_tx
  import iot_sensor_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ACK_HOLDOFF  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ack,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HO_W   = (ACK_HOLDOFF > 0) ? $clog2(ACK_HOLDOFF + 1) : 1;

  logic            fifo_full, fifo_empty, pop, capture;
  logic [7:0]      fifo_rd_data;

  logic            in_ack_q;
  logic [HO_W-1:0] holdoff_q;

  uart_tx_state_e    state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_done_q, tx_done_d;
  logic              bit_end;

  pkt_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (capture),
    .wr_data (in_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Holdoff masks in_valid while the framer's registered valid still reflects the taken byte.
  assign capture = in_valid && !fifo_full && (holdoff_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ack_q  <= 1'b0;
      holdoff_q <= '0;
    end else begin
      in_ack_q <= capture;
      if (capture)              holdoff_q <= HO_W'(ACK_HOLDOFF);
      else if (holdoff_q != '0) holdoff_q <= holdoff_q - 1'b1;
    end
  end

  assign bit_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_done_d = 1'b0;
    pop       = 1'b0;

    if (state_q != StIdle) baud_d = bit_end ? '0 : baud_q + 1'b1;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more bytes are queued.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd_data;
            state_d = StStart;
          end else begin
            tx_done_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_done_q <= tx_done_d;
    end
  end

  // Line is decoded from registered state so reset forces it high asynchronously.
  always_comb begin
    uart_tx = UART_IDLE_LEVEL;
    case (state_q)
      StStart:  uart_tx = 1'b0;
      StData:   uart_tx = shift_q[bit_q];
`ifdef UART_PARITY_EN
      StParity: uart_tx = even_parity(shift_q);
`endif
      default:  uart_tx = UART_IDLE_LEVEL;
    endcase
  end

  assign in_ack  = in_ack_q;
  assign tx_busy = (state_q != StIdle);
  assign tx_done = tx_done_q;

endmodule

// File: doc/packet_uart_tx.md
Name: packet_uart_tx

Overview:
Downstream consumer of the packet framer's byte stream. Accepts framed bytes over the valid/ack handshake, buffers them in a small byte FIFO and serialises them onto a UART line (8N1 by default, LSB first). It is the physical transmit stage between packet framing and the off-chip radio/host link.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 4..65535
FIFO_DEPTH, 16, byte FIFO entries; power of two, 4..64
ACK_HOLDOFF, 2, cycles after an accepted byte during which in_valid is ignored

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_data  input  8  byte from framer (packet_data)
in_valid  input  1  in_data valid (packet_valid)
in_ack  output  1  one-cycle accept pulse (drives framer packet_ack)
uart_tx  output  1  serial line, idle high
tx_busy  output  1  serialiser not in IDLE
fifo_level  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered
tx_done  output  1  one-cycle pulse when a stop bit completes and FIFO is empty

Behaviour:
- Reset is asynchronous and active-low; clk is the only clock. Reset values: in_ack=0, uart_tx=1, tx_busy=0, fifo_level=0, tx_done=0. FIFO pointers, holdoff counter, bit counter and baud counter are all cleared.
- Reset mid-frame: the line returns high immediately and buffered bytes are discarded.
- Capture: in cycle t the byte is captured when in_valid=1, FIFO not full and holdoff=0.
  - in_data is written to the FIFO at the end of t.
  - in_ack is registered and is high in t+1 only.
  - The holdoff counter loads ACK_HOLDOFF, so capture is blocked in t+1..t+ACK_HOLDOFF. This covers the framer's registered-output latency. Earliest next capture is t+ACK_HOLDOFF+1.
- Full: no capture and in_ack stays 0. The byte is held upstream with no loss.
- fifo_level updates one cycle after a write or read. A simultaneous write and read leaves the level unchanged. Pointers wrap modulo FIFO_DEPTH and an extra MSB distinguishes full from empty.
- Serialiser FSM, states IDLE, START, DATA, PARITY (only when the optional feature is compiled in), STOP:
  - IDLE: if the FIFO is not empty, pop into the shift register and go to START. The pop happens in the cycle after the write at the earliest, and uart_tx goes low the cycle after the pop.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles. A 3-bit counter selects the bit and wraps after bit 7.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. At the end of STOP, if the FIFO is not empty, pop and go straight to START with no idle gap. Otherwise go to IDLE and pulse tx_done.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary. All bit periods are exactly CLKS_PER_BIT cycles.
- tx_busy=1 in every state except IDLE.
- Simultaneous capture and pop on an empty FIFO is impossible by construction, because a pop needs a non-empty FIFO in the previous cycle.
- A capture while the FIFO is full and a pop is in progress is not allowed: full is evaluated on the registered level.

Optional Feature:
- Macro UART_PARITY_EN.
  - Defined: the PARITY state is inserted between DATA and STOP and transmits the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 11 bit periods.
  - Undefined: no PARITY state; frame is 10 bit periods (8N1).

Decomposition:
- Shared package iot_sensor_pkg gains:
  - the uart_tx_state_e enum (IDLE/START/DATA/PARITY/STOP)
  - UART_DATA_BITS=8
  - UART_IDLE_LEVEL=1'b1
- One sub-module: pkt_byte_fifo.
  - Parameterised synchronous FIFO with wr_en/rd_en/full/empty/level, same clk/rst_n.
  - packet_uart_tx instantiates it and holds the handshake and serialiser logic.

Test Plan:
- Reset line state (CLKS_PER_BIT=4): assert rst_n=0 -> uart_tx=1, in_ack=0, fifo_level=0.
- Release reset, present 0xAA with in_valid=1 -> in_ack high exactly one cycle; uart_tx low from 2 cycles after capture for 4 cycles; then 0,1,0,1,0,1,0,1 at 4 cycles each; then high 4 cycles; tx_done pulses once.
- Hold in_valid=1 continuously with 0x55 -> acks spaced exactly 3 cycles apart (ACK_HOLDOFF=2); bytes go out back-to-back with no idle cycle between stop and next start.
- FIFO_DEPTH=4, CLKS_PER_BIT=16, burst of 10 bytes -> fifo_level saturates at 4; in_ack withheld while full; all 10 bytes appear on uart_tx in order and none is lost.
- Framer integration: send one 11-byte packet (AA, sensor ID, 00, 06, 4 timestamp bytes, data MSB/LSB, checksum) -> decoded line bytes equal the framer's byte sequence and the XOR of bytes 0..9 equals byte 10.
- With UART_PARITY_EN defined, send 0x07 -> parity bit = 1; frame length 11×CLKS_PER_BIT; assert rst_n mid-DATA -> uart_tx=1 immediately and the FIFO is empty after release.
